// File: rtl/reg_bank_dumper.sv
// Walks the register bank through its debug read port and streams every word
// as four little-endian bytes over a valid/ready byte interface.
module reg_bank_dumper #(
    parameter int BANK_SIZE   = 32,
    parameter int ADDR_LENGTH = 5,
    parameter int DATA_LENGTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    output logic [ADDR_LENGTH-1:0] o_rdAddr,
    input  logic [DATA_LENGTH-1:0] i_rdData,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic                   o_busy,
    output logic                   o_done
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        SEND,
        DONE
    } state_t;

    localparam logic [ADDR_LENGTH-1:0] LAST_ADDR = ADDR_LENGTH'(BANK_SIZE - 1);

    state_t                 state_q, state_d;
    logic [ADDR_LENGTH-1:0] addr_q,  addr_d;
    logic [DATA_LENGTH-1:0] word_q,  word_d;
    logic [1:0]             idx_q,   idx_d;
    logic                   xfer;

    assign xfer = (state_q == SEND) && i_tx_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                addr_d = '0;
                idx_d  = '0;
                if (i_start) state_d = SETUP;
            end
            // Address held a full cycle so a registered bank read also settles.
            SETUP: state_d = LOAD;
            LOAD: begin
                word_d  = i_rdData;
                idx_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                if (xfer) begin
                    if (idx_q != 2'd3) begin
                        idx_d = idx_q + 2'd1;
                    end else if (addr_q != LAST_ADDR) begin
                        addr_d  = addr_q + ADDR_LENGTH'(1);
                        state_d = SETUP;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                addr_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only; i_tx_ready never reaches o_tx_valid.
    assign o_rdAddr   = addr_q;
    assign o_tx_valid = (state_q == SEND);
    assign o_tx_data  = (state_q == SEND) ? word_q[{idx_q, 3'b000} +: 8] : 8'h00;
    assign o_busy     = (state_q != IDLE);
    assign o_done     = (state_q == DONE);

endmodule

// File: tb/tb_reg_bank_dumper.sv
// Randomised bench for reg_bank_dumper: a timing/stream model of the dump
// checked every cycle, plus literal expectations for the canonical scenarios.
module tb_reg_bank_dumper;

    localparam int NB     = 32;
    localparam int NBYTES = NB * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        done;

    logic [31:0] bank [NB];
    assign rd_data = bank[rd_addr];

    always #5 clk = ~clk;

    reg_bank_dumper #(
        .BANK_SIZE  (32),
        .ADDR_LENGTH(5),
        .DATA_LENGTH(32)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .o_rdAddr  (rd_addr),
        .i_rdData  (rd_data),
        .o_tx_data (tx_data),
        .o_tx_valid(tx_valid),
        .i_tx_ready(ready),
        .o_busy    (busy),
        .o_done    (done)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: edge counter, bytes accepted, edge of last register boundary.
    int          t           = 0;
    bit          m_active    = 1'b0;
    int          m_sent      = 0;
    int          m_bound     = 0;
    int          m_done_edge = -100;
    int          e0          = 0;
    logic [31:0] m_word      = '0;
    bit          prev_valid  = 1'b0;
    logic [7:0]  prev_data   = '0;
    int          done_cnt    = 0;
    int          dut_done_t  = 0;
    logic [7:0]  logb [NBYTES];
    bit          exp_valid;
    bit          exp_done;

    // Compare process: sampled 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            t++;
            if (rst) begin
                m_active    = 1'b0;
                m_sent      = 0;
                m_done_edge = -100;
                chk("rst_valid", 32'(tx_valid), 32'd0);
                chk("rst_busy",  32'(busy),     32'd0);
                chk("rst_done",  32'(done),     32'd0);
                chk("rst_addr",  32'(rd_addr),  32'd0);
                chk("rst_data",  32'(tx_data),  32'd0);
                prev_valid = 1'b0;
                prev_data  = tx_data;
            end else begin
                if (prev_valid && !ready) begin
                    chk("hold_valid", 32'(tx_valid), 32'd1);
                    chk("hold_data",  32'(tx_data),  32'(prev_data));
                end
                if (m_active && t == m_done_edge + 1) begin
                    m_active = 1'b0;
                end else if (!m_active && start) begin
                    m_active    = 1'b1;
                    m_sent      = 0;
                    m_bound     = t;
                    e0          = t;
                    m_done_edge = -100;
                end else if (m_active && prev_valid && ready) begin
                    logb[m_sent] = prev_data;
                    m_sent++;
                    if (m_sent % 4 == 0) begin
                        if (m_sent == NBYTES) m_done_edge = t;
                        else                  m_bound     = t;
                    end
                end
                if (m_active && m_sent < NBYTES && t == m_bound + 1)
                    m_word = bank[m_sent / 4];

                exp_valid = m_active && (m_sent < NBYTES) && (t >= m_bound + 2);
                exp_done  = m_active && (t == m_done_edge);
                chk("busy",  32'(busy),     32'(m_active));
                chk("done",  32'(done),     32'(exp_done));
                chk("valid", 32'(tx_valid), 32'(exp_valid));
                if (exp_valid)
                    chk("data", 32'(tx_data), 32'(m_word[8*(m_sent%4) +: 8]));
                if (!exp_done)
                    chk("addr", 32'(rd_addr), m_active ? 32'(m_sent / 4) : 32'd0);
                if (done) begin
                    done_cnt++;
                    dut_done_t = t;
                end
                prev_valid = exp_valid;
                prev_data  = tx_data;
            end
        end
    end

    // One dump: optional random backpressure, a 5-cycle stall at byte stall_at,
    // overwrite of reg[5] while byte mutate_at is presented, reset at abort_at.
    task automatic dump(input bit rnd, input int stall_at, input int mutate_at,
                        input int abort_at, output int off, output int ndone);
        int c0;
        int stall;
        bit stalled;
        bit aborted;
        c0      = done_cnt;
        stall   = 0;
        stalled = 1'b0;
        aborted = 1'b0;
        @(negedge clk);
        start = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (done_cnt != c0 && t >= dut_done_t + 3) break;
            if (abort_at >= 0 && m_sent == abort_at) begin
                rst = 1'b1;
                #1;
                chk("async_rst_valid", 32'(tx_valid), 32'd0);
                chk("async_rst_busy",  32'(busy),     32'd0);
                chk("async_rst_done",  32'(done),     32'd0);
                chk("async_rst_addr",  32'(rd_addr),  32'd0);
                chk("async_rst_data",  32'(tx_data),  32'd0);
                @(negedge clk);
                @(negedge clk);
                rst     = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (rnd) start = prev_valid && ($urandom_range(0, 7) == 0);
            else     start = (t + 1 == e0 + 50) || (t + 1 == e0 + 192) || (t + 1 == e0 + 193);
            if (stall > 0) begin
                ready = 1'b0;
                stall--;
            end else if (!stalled && m_sent == stall_at && prev_valid) begin
                ready   = 1'b0;
                stall   = 4;
                stalled = 1'b1;
            end else begin
                ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (m_sent == mutate_at && prev_valid) bank[5] = 32'h1234_5678;
            @(negedge clk);
        end
        start = 1'b0;
        ready = 1'b1;
        if (!aborted && done_cnt == c0) chk("done_timeout", 32'd0, 32'd1);
        off   = dut_done_t - e0;
        ndone = done_cnt - c0;
    endtask

    int off;
    int nd;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b1;
        for (int k = 0; k < NB; k++) bank[k] = 32'hA500_0000 | 32'(k);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full dump, no backpressure, starts at E50/E192/E193 ignored.
        dump(1'b0, -1, -1, -1, off, nd);
        chk("A_done_edge", 32'(off), 32'd192);
        chk("A_done_cnt",  32'(nd),  32'd1);
        chk("A_b0",   32'(logb[0]),   32'h00);
        chk("A_b1",   32'(logb[1]),   32'h00);
        chk("A_b2",   32'(logb[2]),   32'h00);
        chk("A_b3",   32'(logb[3]),   32'hA5);
        chk("A_b124", 32'(logb[124]), 32'h1F);
        chk("A_b127", 32'(logb[127]), 32'hA5);

        // Five-cycle stall on reg[3] byte 2.
        dump(1'b0, 14, -1, -1, off, nd);
        chk("B_done_edge", 32'(off), 32'd197);
        chk("B_done_cnt",  32'(nd),  32'd1);
        chk("B_b14", 32'(logb[14]), 32'h00);
        chk("B_b15", 32'(logb[15]), 32'hA5);

        // reg[5] overwritten after capture.
        dump(1'b1, -1, 20, -1, off, nd);
        chk("C_done_cnt", 32'(nd), 32'd1);
        chk("C_b20", 32'(logb[20]), 32'h05);
        chk("C_b21", 32'(logb[21]), 32'h00);
        chk("C_b22", 32'(logb[22]), 32'h00);
        chk("C_b23", 32'(logb[23]), 32'hA5);
        bank[5] = 32'hA500_0005;

        // Reset after 50 bytes, then a fresh dump from register 0.
        dump(1'b1, -1, -1, 50, off, nd);
        chk("D_no_done", 32'(nd), 32'd0);
        dump(1'b1, -1, -1, -1, off, nd);
        chk("E_done_cnt", 32'(nd), 32'd1);
        chk("E_b0", 32'(logb[0]), 32'h00);
        chk("E_b3", 32'(logb[3]), 32'hA5);
        chk("E_b4", 32'(logb[4]), 32'h01);

        // Random bank contents with random backpressure.
        repeat (2) begin
            for (int k = 0; k < NB; k++) bank[k] = $urandom;
            dump(1'b1, -1, -1, -1, off, nd);
            chk("R_done_cnt", 32'(nd), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
